// File: rtl/lc3b_types.sv
// Shared LC-3b types: word, cache line and the L2 arbiter state encoding.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D
  } arb_state_t;

endpackage

// File: rtl/l2_arbiter_if.sv
// Signal bundle between the I/D caches, the L2 arbiter and the L2.
interface l2_arbiter_if;
  import lc3b_types::*;

  logic     icache_read;
  lc3b_word icache_address;
  logic     icache_resp;
  lc3b_line icache_rdata;

  logic     dcache_read;
  logic     dcache_write;
  lc3b_word dcache_address;
  lc3b_line dcache_wdata;
  logic     dcache_resp;
  lc3b_line dcache_rdata;

  logic     L2_read;
  logic     L2_write;
  lc3b_word L2_address;
  lc3b_line L2_wdata;
  logic     L2_resp;
  lc3b_line L2_rdata;

  modport arb (
    input  icache_read, icache_address,
    output icache_resp, icache_rdata,
    input  dcache_read, dcache_write,
    input  dcache_address, dcache_wdata,
    output dcache_resp, dcache_rdata,
    output L2_read, L2_write, L2_address, L2_wdata,
    input  L2_resp, L2_rdata
  );

  modport env (
    output icache_read, icache_address,
    input  icache_resp, icache_rdata,
    output dcache_read, dcache_write,
    output dcache_address, dcache_wdata,
    input  dcache_resp, dcache_rdata,
    input  L2_read, L2_write, L2_address, L2_wdata,
    output L2_resp, L2_rdata
  );

endinterface

// File: rtl/l2_arbiter.sv
// Two-client (I-cache / D-cache) arbiter in front of a single-port L2.
// Winner's request is latched at grant so L2 sees a stable payload.
module l2_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned RR_ENABLE = 1
) (
  input  logic     clk,
  input  logic     rst_n,

  input  logic     icache_read,
  input  lc3b_word icache_address,
  output logic     icache_resp,
  output lc3b_line icache_rdata,

  input  logic     dcache_read,
  input  logic     dcache_write,
  input  lc3b_word dcache_address,
  input  lc3b_line dcache_wdata,
  output logic     dcache_resp,
  output lc3b_line dcache_rdata,

  output logic     L2_read,
  output logic     L2_write,
  output lc3b_word L2_address,
  output lc3b_line L2_wdata,
  input  logic     L2_resp,
  input  lc3b_line L2_rdata
);

  arb_state_t state;
  arb_state_t state_n;

  lc3b_word addr_q;
  lc3b_line wdata_q;
  logic     rd_q;
  logic     wr_q;
  logic     last_d;

  logic i_req;
  logic d_req;
  logic grant_i;
  logic grant_d;

  assign i_req = icache_read;
  assign d_req = dcache_read | dcache_write;

  always_comb begin
    state_n     = state;
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    icache_resp = 1'b0;
    dcache_resp = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_req && d_req) begin
          // round-robin favours whoever was not served last
          if (RR_ENABLE != 0 && last_d)
            grant_i = 1'b1;
          else
            grant_d = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end else if (i_req) begin
          grant_i = 1'b1;
        end
        if (grant_i) state_n = GRANT_I;
        if (grant_d) state_n = GRANT_D;
      end
      GRANT_I: begin
        icache_resp = L2_resp;
        if (L2_resp) state_n = IDLE;
      end
      GRANT_D: begin
        dcache_resp = L2_resp;
        if (L2_resp) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      last_d  <= 1'b0;
    end else if (grant_i) begin
      addr_q  <= icache_address;
      wdata_q <= '0;
      rd_q    <= 1'b1;
      wr_q    <= 1'b0;
      last_d  <= 1'b0;
    end else if (grant_d) begin
      addr_q  <= dcache_address;
      wdata_q <= dcache_wdata;
      rd_q    <= ~dcache_write;
      wr_q    <= dcache_write;
      last_d  <= 1'b1;
    end else if (state != IDLE && L2_resp) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end
  end

  assign L2_read      = rd_q;
  assign L2_write     = wr_q;
  assign L2_address   = addr_q;
  assign L2_wdata     = wdata_q;
  assign icache_rdata = L2_rdata;
  assign dcache_rdata = L2_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: directed scenarios plus random traffic against
// a transaction-level model of who owns L2 and what it should see.
module tb_l2_arbiter;
  import lc3b_types::*;

  localparam bit RR1 = 1'b1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  l2_arbiter_if bus1 ();
  l2_arbiter_if bus0 ();

  l2_arbiter #(.RR_ENABLE(1)) u_rr (
    .clk            (clk),
    .rst_n          (rst_n),
    .icache_read    (bus1.icache_read),
    .icache_address (bus1.icache_address),
    .icache_resp    (bus1.icache_resp),
    .icache_rdata   (bus1.icache_rdata),
    .dcache_read    (bus1.dcache_read),
    .dcache_write   (bus1.dcache_write),
    .dcache_address (bus1.dcache_address),
    .dcache_wdata   (bus1.dcache_wdata),
    .dcache_resp    (bus1.dcache_resp),
    .dcache_rdata   (bus1.dcache_rdata),
    .L2_read        (bus1.L2_read),
    .L2_write       (bus1.L2_write),
    .L2_address     (bus1.L2_address),
    .L2_wdata       (bus1.L2_wdata),
    .L2_resp        (bus1.L2_resp),
    .L2_rdata       (bus1.L2_rdata)
  );

  l2_arbiter #(.RR_ENABLE(0)) u_fixed (
    .clk            (clk),
    .rst_n          (rst_n),
    .icache_read    (bus0.icache_read),
    .icache_address (bus0.icache_address),
    .icache_resp    (bus0.icache_resp),
    .icache_rdata   (bus0.icache_rdata),
    .dcache_read    (bus0.dcache_read),
    .dcache_write   (bus0.dcache_write),
    .dcache_address (bus0.dcache_address),
    .dcache_wdata   (bus0.dcache_wdata),
    .dcache_resp    (bus0.dcache_resp),
    .dcache_rdata   (bus0.dcache_rdata),
    .L2_read        (bus0.L2_read),
    .L2_write       (bus0.L2_write),
    .L2_address     (bus0.L2_address),
    .L2_wdata       (bus0.L2_wdata),
    .L2_resp        (bus0.L2_resp),
    .L2_rdata       (bus0.L2_rdata)
  );

  int checks = 0;
  int errors = 0;

  // model: owner 0 = nobody, 1 = I-cache, 2 = D-cache
  int           st = 0;
  int           lat = 0;
  int           lat_force = -1;
  bit           last_d = 1'b0;
  bit           i_pend = 1'b0;
  bit           d_pend = 1'b0;
  bit           d_wr = 1'b0;
  bit           d_rd = 1'b0;
  bit           idle_pulse = 1'b0;
  logic [15:0]  i_addr = '0;
  logic [15:0]  d_addr = '0;
  logic [127:0] d_wdata = '0;
  logic [15:0]  cap_addr = '0;
  logic [127:0] cap_wdata = '0;
  bit           cap_wr = 1'b0;
  int           i_resp_cnt = 0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive();
    bus1.icache_read    = i_pend;
    bus1.icache_address = i_addr;
    bus1.dcache_read    = d_pend && d_rd;
    bus1.dcache_write   = d_pend && d_wr;
    bus1.dcache_address = d_addr;
    bus1.dcache_wdata   = d_wdata;
  endtask

  // one clock cycle, entered and left at a falling edge
  task automatic step(input int mode);
    bit resp_now;
    int nst;
    int w;
    chk("l2_read", bus1.L2_read, st == 1 || (st == 2 && !cap_wr));
    chk("l2_write", bus1.L2_write, st == 2 && cap_wr);
    if (st != 0) begin
      chk("l2_address", bus1.L2_address, cap_addr);
      if (cap_wr) chk("l2_wdata", bus1.L2_wdata, cap_wdata);
    end
    resp_now = 1'b0;
    if (st != 0) begin
      if (lat == 0) resp_now = 1'b1;
      else lat--;
    end
    bus1.L2_resp  = resp_now || (st == 0 && idle_pulse);
    bus1.L2_rdata = rnd_line();
    #1;
    chk("icache_resp", bus1.icache_resp, st == 1 && resp_now);
    chk("dcache_resp", bus1.dcache_resp, st == 2 && resp_now);
    if (resp_now && st == 1)
      chk("icache_rdata", bus1.icache_rdata, bus1.L2_rdata);
    if (resp_now && st == 2)
      chk("dcache_rdata", bus1.dcache_rdata, bus1.L2_rdata);
    if (bus1.icache_resp === 1'b1) i_resp_cnt++;
    nst = st;
    if (resp_now) begin
      if (st == 1) i_pend = 1'b0;
      else d_pend = 1'b0;
      nst = 0;
    end
    if (mode == 1) begin
      if (!i_pend && $urandom_range(2) == 0) begin
        i_pend = 1'b1;
        i_addr = 16'($urandom);
      end
      if (!d_pend && $urandom_range(2) == 0) begin
        d_pend  = 1'b1;
        d_wr    = 1'($urandom);
        d_rd    = d_wr ? 1'($urandom) : 1'b1;
        d_addr  = 16'($urandom);
        d_wdata = rnd_line();
      end
      if (st != 0 && !resp_now && $urandom_range(1) == 0) begin
        if (st == 1) i_addr = 16'($urandom);
        else begin
          d_addr  = 16'($urandom);
          d_wdata = rnd_line();
        end
      end
      idle_pulse = ($urandom_range(4) == 0);
    end else if (mode == 2) begin
      if (!i_pend) begin
        i_pend = 1'b1;
        i_addr = 16'($urandom);
      end
      if (!d_pend) begin
        d_pend  = 1'b1;
        d_wr    = 1'b1;
        d_rd    = 1'b0;
        d_addr  = 16'($urandom);
        d_wdata = rnd_line();
      end
    end
    drive();
    if (st == 0) begin
      w = 0;
      if (i_pend && d_pend) w = (RR1 && last_d) ? 1 : 2;
      else if (d_pend) w = 2;
      else if (i_pend) w = 1;
      if (w != 0) begin
        nst    = w;
        last_d = (w == 2);
        if (w == 1) begin
          cap_addr  = i_addr;
          cap_wdata = '0;
          cap_wr    = 1'b0;
        end else begin
          cap_addr  = d_addr;
          cap_wdata = d_wdata;
          cap_wr    = d_wr;
        end
        lat = (lat_force >= 0) ? lat_force : int'($urandom_range(3));
      end
    end
    st = nst;
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus1.L2_resp = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_l2_read", bus1.L2_read, 1'b0);
    chk("rst_l2_write", bus1.L2_write, 1'b0);
    chk("rst_icache_resp", bus1.icache_resp, 1'b0);
    chk("rst_dcache_resp", bus1.dcache_resp, 1'b0);
    chk("rst_l2_address", bus1.L2_address, 16'h0000);
    st     = 0;
    lat    = 0;
    last_d = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int dcnt;
  int icnt;

  initial begin
    i_pend = 1'b0;
    d_pend = 1'b0;
    drive();
    bus1.L2_resp  = 1'b0;
    bus1.L2_rdata = '0;
    bus0.icache_read    = 1'b0;
    bus0.icache_address = 16'h1111;
    bus0.dcache_read    = 1'b0;
    bus0.dcache_write   = 1'b0;
    bus0.dcache_address = 16'h2222;
    bus0.dcache_wdata   = '0;
    bus0.L2_resp        = 1'b0;
    bus0.L2_rdata       = '0;
    @(negedge clk);
    do_reset();

    // lone I-cache read, L2 answers on the third cycle of L2_read
    i_pend = 1'b1;
    i_addr = 16'h1230;
    lat_force = 2;
    drive();
    i_resp_cnt = 0;
    repeat (8) step(0);
    chk("i_only_resp_count", i_resp_cnt, 1);

    // simultaneous I read and D write straight after reset
    do_reset();
    i_pend = 1'b1;
    i_addr = 16'h0100;
    d_pend = 1'b1;
    d_wr = 1'b1;
    d_rd = 1'b0;
    d_addr = 16'h0200;
    d_wdata = {16{8'hA5}};
    lat_force = 1;
    drive();
    repeat (10) step(0);

    // both clients keep requesting: grants must alternate
    lat_force = 0;
    repeat (24) step(2);
    lat_force = 1;
    repeat (6) step(0);
    i_pend = 1'b0;
    d_pend = 1'b0;
    drive();
    repeat (4) step(0);

    // address change while granted must not reach L2
    d_pend = 1'b1;
    d_wr = 1'b0;
    d_rd = 1'b1;
    d_addr = 16'h0200;
    lat_force = 3;
    drive();
    step(0);
    d_addr = 16'h0300;
    drive();
    repeat (8) step(0);

    // reset while a D write is on the bus, request held across it
    d_pend = 1'b1;
    d_wr = 1'b1;
    d_rd = 1'b0;
    d_addr = 16'h0440;
    d_wdata = rnd_line();
    drive();
    step(0);
    step(0);
    chk("pre_rst_l2_write", bus1.L2_write, 1'b1);
    do_reset();
    repeat (8) step(0);

    // stray L2_resp with nobody granted
    idle_pulse = 1'b1;
    step(0);
    idle_pulse = 1'b0;
    repeat (2) step(0);

    lat_force = -1;
    repeat (2000) step(1);
    idle_pulse = 1'b0;
    i_pend = 1'b0;
    d_pend = 1'b0;
    drive();
    repeat (6) step(0);

    // fixed-priority instance: D wins for as long as it requests
    bus0.icache_read = 1'b1;
    bus0.dcache_read = 1'b1;
    dcnt = 0;
    repeat (20) begin
      bus0.L2_resp  = bus0.L2_read | bus0.L2_write;
      bus0.L2_rdata = rnd_line();
      #1;
      chk("fixed_icache_resp", bus0.icache_resp, 1'b0);
      if (bus0.L2_read === 1'b1)
        chk("fixed_l2_address", bus0.L2_address, 16'h2222);
      if (bus0.dcache_resp === 1'b1) dcnt++;
      @(negedge clk);
    end
    chk("fixed_d_grants", dcnt >= 8, 1'b1);
    bus0.dcache_read = 1'b0;
    icnt = 0;
    repeat (6) begin
      bus0.L2_resp = bus0.L2_read | bus0.L2_write;
      #1;
      if (bus0.icache_resp === 1'b1) icnt++;
      @(negedge clk);
    end
    chk("fixed_i_served", icnt >= 1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_arbiter.md
L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 SHALL have parameter RR_ENABLE, default 1: 1 = round-robin between clients, 0 = fixed D-cache priority.
REQ-002 SHALL use one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, async active-low reset.
REQ-003 SHALL have port icache_read input 1: I-cache line read request, level, held until icache_resp.
REQ-004 SHALL have port icache_address input 16 (lc3b_word): I-cache line address.
REQ-005 SHALL have port icache_resp output 1: one-cycle completion pulse to I-cache.
REQ-006 SHALL have port icache_rdata output 128 (lc3b_line): read line to I-cache.
REQ-007 SHALL have ports dcache_read/dcache_write input 1 each: D-cache requests, level, held until dcache_resp.
REQ-008 SHALL have ports dcache_address input 16 and dcache_wdata input 128: D-cache address and writeback line.
REQ-009 SHALL have ports dcache_resp output 1 and dcache_rdata output 128: D-cache completion pulse and read line.
REQ-010 SHALL have ports L2_read/L2_write output 1 each: requests to L2, level, held until L2_resp.
REQ-011 SHALL have ports L2_address output 16 and L2_wdata output 128: registered request payload to L2.
REQ-012 SHALL have ports L2_resp input 1 and L2_rdata input 128: one-cycle completion pulse and read data from L2.

Function
REQ-013 SHALL implement FSM states IDLE, GRANT_I, GRANT_D; reset state IDLE.
REQ-014 In IDLE with exactly one client requesting, SHALL enter that client's GRANT state on the next edge.
REQ-015 On simultaneous I and D requests in IDLE: RR_ENABLE=1 SHALL grant the client not served last (D after reset); RR_ENABLE=0 SHALL always grant D.
REQ-016 On grant, SHALL capture the address, wdata and op of the winner into registers; L2_* outputs SHALL be driven only from these registers.
REQ-017 If dcache_read and dcache_write are both high, SHALL treat the request as a write.
REQ-018 In GRANT_x, SHALL hold L2_read or L2_write high and the payload stable until L2_resp is sampled high.
REQ-019 When L2_resp is high in GRANT_x, SHALL assert x_resp combinationally in the same cycle, pass L2_rdata to x_rdata, and return to IDLE next edge.
REQ-020 Latency: request high at edge N -> L2_read/L2_write high in cycle N+1; client resp in the cycle of L2_resp; minimum 2 cycles request-to-resp.
REQ-021 The non-granted client's resp SHALL stay 0; its request SHALL remain pending and SHALL be granted from IDLE directly after the current transaction.
REQ-022 L2_resp in IDLE SHALL be ignored (no client resp, no state change).
REQ-023 Client request changes during GRANT_x SHALL NOT alter the captured payload.
REQ-024 SHALL update the last-served flag when the grant is issued.
REQ-025 icache_rdata/dcache_rdata SHALL equal L2_rdata whenever the matching resp is high; their values are don't-care otherwise.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, L2_read=0, L2_write=0, icache_resp=0, dcache_resp=0, last-served=I, and payload registers=0.
REQ-027 A reset mid-transaction SHALL abandon it; after release the arbiter SHALL re-arbitrate the still-held requests from IDLE.

Structure
REQ-028 lc3b_word, lc3b_line and the arbiter state enum SHALL live in the shared lc3b_types package.
REQ-029 The block SHALL be flat, with no sub-modules; the FSM and payload registers are in one module.

Verification
REQ-030 I-cache read of 0x1230 alone, L2_resp 3 cycles after L2_read: L2_address=0x1230, icache_resp one pulse carrying L2_rdata, dcache_resp=0.
REQ-031 I read 0x0100 and D write 0x0200 (wdata 0xA5..A5) in the same cycle, RR_ENABLE=1, after reset: D granted first (L2_write, wdata matches), then I with no idle gap beyond IDLE.
REQ-032 Back-to-back simultaneous requests, RR_ENABLE=1: grants alternate D, I, D, I; with RR_ENABLE=0 D always wins while it keeps requesting.
REQ-033 Change dcache_address from 0x0200 to 0x0300 mid-transaction: L2_address stays 0x0200 until L2_resp.
REQ-034 Assert rst_n=0 while in GRANT_D with L2_write high: L2_write drops at once; after release a held D request is re-issued.
REQ-035 Pulse L2_resp in IDLE with no requests: no client resp and state stays IDLE.
